// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default widths for the pattern-sequence player
package seq_pkg;
  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;
  localparam int SEQ_W_DEF   = 6;
  localparam int NUM_SEQ_DEF = 64;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
endpackage

// File: rtl/pb_edge.sv
// pb_edge: 2-flop synchroniser plus delay flop, emitting a one-cycle pulse on a rising level
// Ports: CLK_50/reset (async, active-high), lvl (asynchronous level in), pulse (CLK_50-synchronous rising-edge pulse)
module pb_edge (
  input  logic CLK_50,
  input  logic reset,
  input  logic lvl,
  output logic pulse
);
  // sh_q[0], sh_q[1] form the synchroniser; sh_q[2] is the delayed copy for edge detection
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], lvl};
  always_ff @(posedge CLK_50 or posedge reset)
    if (reset) sh_q <= '0;
    else sh_q <= sh_d;
  assign pulse = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/seq_player.sv
// seq_player: button-selected pattern-sequence player stepping a pattern ROM on a slow strobe
// Ports: CLK_50/reset (async, active-high); up_lvl/dn_lvl async buttons; step_en advance strobe; loop restart-at-end;
//        tag_rd_en/tag_addr -> tag RAM, tag_start/tag_len <- tag RAM; rom_addr -> ROM, rom_data <- ROM;
//        pattern displayed word; seq_num selection; busy in PLAY; done in DONE
module seq_player
  import seq_pkg::*;
#(
  parameter int SEQ_W   = SEQ_W_DEF,
  parameter int NUM_SEQ = NUM_SEQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit WRAP    = 1'b1
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              up_lvl,
  input  logic              dn_lvl,
  input  logic              step_en,
  input  logic              loop,
  output logic              tag_rd_en,
  output logic [SEQ_W-1:0]  tag_addr,
  input  logic [ADDR_W-1:0] tag_start,
  input  logic [ADDR_W-1:0] tag_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pattern,
  output logic [SEQ_W-1:0]  seq_num,
  output logic              busy,
  output logic              done
);
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(NUM_SEQ - 1);
  logic up_e, dn_e, sel_chg;
  state_t state_q, state_d;
  logic [SEQ_W-1:0] seq_num_q, seq_num_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, start_q, start_d, last_q, last_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  pb_edge u_up (.CLK_50(CLK_50), .reset(reset), .lvl(up_lvl), .pulse(up_e));
  pb_edge u_dn (.CLK_50(CLK_50), .reset(reset), .lvl(dn_lvl), .pulse(dn_e));
  always_comb begin
    sel_chg    = up_e ^ dn_e;
    seq_num_d  = seq_num_q;
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    start_d    = start_q;
    last_d     = last_q;
    pattern_d  = pattern_q;
    if (up_e & ~dn_e)
      seq_num_d = (seq_num_q == SEQ_MAX) ? (WRAP ? '0 : SEQ_MAX) : seq_num_q + SEQ_W'(1);
    else if (dn_e & ~up_e)
      seq_num_d = (seq_num_q == '0) ? (WRAP ? SEQ_MAX : '0) : seq_num_q - SEQ_W'(1);
    // An accepted press always refetches, even when saturated, so it restarts the sequence.
    if (sel_chg) state_d = S_FETCH;
    else
      case (state_q)
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          start_d    = tag_start;
          last_d     = tag_start + tag_len - ADDR_W'(1);
          rom_addr_d = tag_start;
          state_d    = (tag_len == '0) ? S_DONE : S_PLAY;
          pattern_d  = (tag_len == '0) ? '0 : pattern_q;
        end
        S_PLAY:
          if (step_en) begin
            pattern_d  = rom_data;
            rom_addr_d = (rom_addr_q != last_q) ? rom_addr_q + ADDR_W'(1) : (loop ? start_q : rom_addr_q);
            state_d    = (rom_addr_q == last_q && !loop) ? S_DONE : S_PLAY;
          end
        default: ;
      endcase
  end
  always_ff @(posedge CLK_50 or posedge reset)
    if (reset) begin
      state_q    <= S_FETCH;
      seq_num_q  <= '0;
      rom_addr_q <= '0;
      start_q    <= '0;
      last_q     <= '0;
      pattern_q  <= '0;
    end else begin
      state_q    <= state_d;
      seq_num_q  <= seq_num_d;
      rom_addr_q <= rom_addr_d;
      start_q    <= start_d;
      last_q     <= last_d;
      pattern_q  <= pattern_d;
    end
  // The reset state is FETCH, but the read strobe must read low while reset is held.
  assign tag_rd_en = (state_q == S_FETCH) & ~reset;
  assign tag_addr  = seq_num_q;
  assign rom_addr  = rom_addr_q;
  assign pattern   = pattern_q;
  assign seq_num   = seq_num_q;
  assign busy      = (state_q == S_PLAY);
  assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed self-checking bench with a pattern scoreboard for seq_player (WRAP=1 and WRAP=0)
module tb_seq_player;
  logic CLK_50, reset;
  logic up0, dn0, step0, loop0, dn1;
  logic tag_rd_en0, tag_rd_en1, busy0, busy1, done0, done1;
  logic [5:0] tag_addr0, tag_addr1, seq_num0, seq_num1;
  logic [9:0] ts0, tl0, ts1, tl1, rom_addr0, rom_addr1;
  logic [15:0] rom_data0, rom_data1, pattern0, pattern1;
  logic [9:0] tag_s [64];
  logic [9:0] tag_l [64];
  logic [15:0] exp_q [$];
  logic [9:0] ea;
  int checks = 0, failures = 0, cnt, first;
  seq_player #(.WRAP(1'b1)) u0 (
    .CLK_50(CLK_50), .reset(reset), .up_lvl(up0), .dn_lvl(dn0), .step_en(step0), .loop(loop0),
    .tag_rd_en(tag_rd_en0), .tag_addr(tag_addr0), .tag_start(ts0), .tag_len(tl0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .pattern(pattern0), .seq_num(seq_num0),
    .busy(busy0), .done(done0));
  seq_player #(.WRAP(1'b0)) u1 (
    .CLK_50(CLK_50), .reset(reset), .up_lvl(1'b0), .dn_lvl(dn1), .step_en(1'b0), .loop(1'b0),
    .tag_rd_en(tag_rd_en1), .tag_addr(tag_addr1), .tag_start(ts1), .tag_len(tl1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .pattern(pattern1), .seq_num(seq_num1),
    .busy(busy1), .done(done1));
  assign rom_data0 = 16'(rom_addr0);
  assign rom_data1 = 16'(rom_addr1);
  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) begin
    if (tag_rd_en0) begin
      ts0 <= tag_s[tag_addr0];
      tl0 <= tag_l[tag_addr0];
    end
    if (tag_rd_en1) begin
      ts1 <= tag_s[tag_addr1];
      tl1 <= tag_l[tag_addr1];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_50);
  endtask
  task automatic press(input logic is_up);
    if (is_up) up0 = 1'b1; else dn0 = 1'b1;
    cyc(4);
    up0 = 1'b0;
    dn0 = 1'b0;
    cyc(4);
  endtask
  task automatic step_chk(input string tag, input logic [9:0] exp_addr);
    exp_q.push_back(16'(ea));
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    if (exp_q.size() == 0) chk({tag, "_queue"}, 32'(0), 32'(1));
    else chk(tag, 32'(pattern0), 32'(exp_q.pop_front()));
    chk({tag, "_addr"}, 32'(rom_addr0), 32'(exp_addr));
    cyc(1);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      tag_s[i] = 10'(i * 4);
      tag_l[i] = 10'd2;
    end
    tag_s[0] = 10'd10;
    tag_s[1] = 10'd100; tag_l[1] = 10'd3;
    tag_s[2] = 10'd500; tag_l[2] = 10'd0;
    tag_s[63] = 10'd1022; tag_l[63] = 10'd3;
    ts0 = '0; tl0 = '0; ts1 = '0; tl1 = '0;
    reset = 1'b1; up0 = 0; dn0 = 0; step0 = 0; loop0 = 1; dn1 = 0;
    cyc(3);
    chk("rst_seq", 32'(seq_num0), 32'(0));
    chk("rst_addr", 32'(rom_addr0), 32'(0));
    chk("rst_pat", 32'(pattern0), 32'(0));
    chk("rst_rd", 32'(tag_rd_en0), 32'(0));
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_done", 32'(done0), 32'(0));
    reset = 1'b0;
    cyc(6);
    chk("init_busy", 32'(busy0), 32'(1));
    chk("init_addr", 32'(rom_addr0), 32'(10));
    up0 = 1'b1;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (seq_num0 == 6'd1 && first == 0) first = i;
      if (tag_rd_en0 && tag_addr0 == 6'd1) cnt++;
    end
    up0 = 1'b0;
    chk("held_first", 32'(first), 32'(3));
    chk("held_fetches", 32'(cnt), 32'(1));
    chk("held_seq", 32'(seq_num0), 32'(1));
    cyc(3);
    chk("play1_addr", 32'(rom_addr0), 32'(100));
    chk("play1_pat", 32'(pattern0), 32'(0));
    ea = 10'd100;
    for (int n = 0; n < 6; n++) begin
      logic [9:0] nx;
      nx = (ea == 10'd102) ? 10'd100 : ea + 10'd1;
      step_chk("loop_step", nx);
      ea = nx;
    end
    up0 = 1'b1;
    cyc(2);
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    chk("coll_seq", 32'(seq_num0), 32'(2));
    chk("coll_pat", 32'(pattern0), 32'(102));
    chk("coll_addr", 32'(rom_addr0), 32'(100));
    chk("coll_rd", 32'(tag_rd_en0), 32'(1));
    chk("coll_busy", 32'(busy0), 32'(0));
    cyc(1);
    chk("empty_load_done", 32'(done0), 32'(0));
    cyc(1);
    chk("empty_done", 32'(done0), 32'(1));
    chk("empty_pat", 32'(pattern0), 32'(0));
    chk("empty_addr", 32'(rom_addr0), 32'(500));
    up0 = 1'b0;
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    cyc(1);
    chk("empty_step_pat", 32'(pattern0), 32'(0));
    chk("empty_step_done", 32'(done0), 32'(1));
    up0 = 1'b1;
    dn0 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (tag_rd_en0) cnt++;
    end
    up0 = 1'b0;
    dn0 = 1'b0;
    chk("both_fetches", 32'(cnt), 32'(0));
    chk("both_seq", 32'(seq_num0), 32'(2));
    cyc(3);
    press(1'b0);
    press(1'b0);
    chk("dn_to_0", 32'(seq_num0), 32'(0));
    loop0 = 1'b0;
    press(1'b0);
    chk("wrap_dn", 32'(seq_num0), 32'(63));
    chk("stop_start", 32'(rom_addr0), 32'(1022));
    chk("stop_busy", 32'(busy0), 32'(1));
    ea = 10'd1022;
    step_chk("stop_s0", 10'd1023);
    ea = 10'd1023;
    step_chk("stop_s1", 10'd0);
    ea = 10'd0;
    step_chk("stop_s2", 10'd0);
    chk("stop_done", 32'(done0), 32'(1));
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    cyc(1);
    chk("stop_extra_pat", 32'(pattern0), 32'(0));
    chk("stop_extra_done", 32'(done0), 32'(1));
    chk("stop_extra_addr", 32'(rom_addr0), 32'(0));
    press(1'b1);
    chk("wrap_up", 32'(seq_num0), 32'(0));
    loop0 = 1'b1;
    press(1'b1);
    chk("up_to_1", 32'(seq_num0), 32'(1));
    ea = 10'd100;
    step_chk("pre_rst_step", 10'd101);
    #2 reset = 1'b1;
    #1;
    chk("arst_seq", 32'(seq_num0), 32'(0));
    chk("arst_addr", 32'(rom_addr0), 32'(0));
    chk("arst_pat", 32'(pattern0), 32'(0));
    chk("arst_rd", 32'(tag_rd_en0), 32'(0));
    chk("arst_busy", 32'(busy0), 32'(0));
    chk("arst_done", 32'(done0), 32'(0));
    cyc(2);
    reset = 1'b0;
    cyc(6);
    dn1 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (tag_rd_en1 && tag_addr1 == 6'd0) cnt++;
    end
    dn1 = 1'b0;
    chk("sat_seq", 32'(seq_num1), 32'(0));
    chk("sat_refetch", 32'(cnt), 32'(1));
    cyc(2);
    chk("sat_busy", 32'(busy1), 32'(1));
    chk("sat_addr", 32'(rom_addr1), 32'(10));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_player.md
# seq_player

Parametrised pattern-sequence player for the LED/pattern path. It selects a sequence number from debounced up/down buttons using edge-triggered counting with a wrap or saturate mode. It then fetches that sequence's start/length tag from the tag RAM and steps the pattern ROM address on a slow-rate strobe, looping or stopping at the sequence end. Everything runs in the CLK_50 domain; the slow clock reaches the block only as the `step_en` pulse.

## Interface
- `SEQ_W`, 6: sequence-number width.
- `NUM_SEQ`, 64: number of sequences; legal `seq_num` is 0..NUM_SEQ-1; must be ≤ 2^SEQ_W.
- `ADDR_W`, 10: pattern ROM address width.
- `DATA_W`, 16: pattern word width.
- `WRAP`, 1: 1 = `seq_num` wraps at the limits; 0 = saturates.
- `CLK_50` input 1: system clock.
- `reset` input 1: reset, asynchronous, active-high.
- `up_lvl` input 1: debounced "next sequence" level, asynchronous to CLK_50.
- `dn_lvl` input 1: debounced "previous sequence" level, asynchronous.
- `step_en` input 1: one-cycle advance strobe, CLK_50-synchronous; pulses are ≥2 cycles apart.
- `loop` input 1: 1 = restart at sequence end; 0 = stop. Sampled at end of sequence.
- `tag_rd_en` output 1: tag RAM read strobe.
- `tag_addr` output SEQ_W: tag RAM read address.
- `tag_start` input ADDR_W: first ROM address; valid 1 cycle after `tag_rd_en`.
- `tag_len` input ADDR_W: sequence length in words; valid 1 cycle after `tag_rd_en`.
- `rom_addr` output ADDR_W: pattern ROM address, registered.
- `rom_data` input DATA_W: ROM word; valid 1 cycle after `rom_addr` changes.
- `pattern` output DATA_W: currently displayed pattern word.
- `seq_num` output SEQ_W: selected sequence.
- `busy` output 1: high in PLAY.
- `done` output 1: high in DONE.

## Operation
- **Input conditioning.** `up_lvl` and `dn_lvl` each pass through a 2-flop synchroniser plus a delay flop. `up_e` = sync & ~delay, and `dn_e` is formed the same way. A held button therefore produces one step only.
- **Selection.**
  - `up_e` & ~`dn_e`: `seq_num`+1.
  - `dn_e` & ~`up_e`: `seq_num`−1.
  - Both or neither: no change, and no refetch.
- **Selection limits.**
  - WRAP=1: NUM_SEQ−1 + 1 gives 0, and 0 − 1 gives NUM_SEQ−1.
  - WRAP=0: the value holds at the limit. A held-at-limit press still forces a refetch, which restarts the sequence.
- **FSM states:** FETCH, LOAD, PLAY, DONE. The reset state is FETCH.
  - **FETCH:** `tag_rd_en`=1, `tag_addr`=`seq_num`; always goes to LOAD.
  - **LOAD:** captures `start`=`tag_start` and `last`=`tag_start`+`tag_len`−1 (mod 2^ADDR_W), and sets `rom_addr`←`tag_start`.
    - `tag_len`=0: go to DONE with `pattern`←0.
    - Otherwise: go to PLAY.
  - **PLAY, on `step_en`:** `pattern`←`rom_data`. Then:
    - If `rom_addr`≠`last`: `rom_addr`+1 (mod 2^ADDR_W), stay in PLAY.
    - Else if `loop`=1: `rom_addr`←`start`, stay in PLAY.
    - Else: go to DONE.
  - **DONE:** holds `rom_addr` and `pattern`; `step_en` is ignored.
- **Selection change:** any accepted selection change, in any state, moves the FSM to FETCH on the same edge that updates `seq_num`. `pattern` holds its old value until the next step.
- **Reset values:** `seq_num`=0, `rom_addr`=0, `pattern`=0, `tag_rd_en`=0, `busy`=0, `done`=0, and all sync flops 0. Reset asserted mid-PLAY returns the block to FETCH immediately and asynchronously.

## Timing
- **Button to selection:** `up_lvl` rises before edge k → `seq_num` updates at edge k+2 and the state becomes FETCH at k+2.
- **Selection to first step:**
  - FETCH spans cycle k+2..k+3.
  - LOAD spans k+3..k+4, and `rom_addr`=start from k+4.
  - PLAY is entered at k+4, with `rom_data` valid during cycle k+4..k+5.
  - The first `step_en` is honoured from cycle k+4 onward.
- **Step latency:** `pattern` updates 1 edge after `step_en` is high.
- **Early step strobes:** `step_en` during FETCH or LOAD is dropped.
- **Simultaneous events:** a selection edge coinciding with `step_en` in PLAY means the selection wins; there is no pattern update and no address advance.

## Structure
- **Package `seq_pkg`:** FSM state enum (`S_FETCH`, `S_LOAD`, `S_PLAY`, `S_DONE`) and default widths.
- **Sub-module `pb_edge`:** 2-flop sync + delay + rising-edge pulse; instantiated twice.
- **Top level:** `seq_player` holds the selection counter, FSM and address datapath.

## Test plan
- **Held button:** reset, hold `up_lvl` for 50 cycles → `seq_num`=1 exactly once, at cycle 2 after first sampling; `tag_rd_en` pulses once with `tag_addr`=1.
- **Wrap/saturate:** WRAP=1 at `seq_num`=0 with a `dn` press → 63. WRAP=0, same press → `seq_num` stays 0 and a refetch occurs.
- **Looped play:** tag start=100, len=3, `loop`=1, `rom_data`=addr → 6 steps give `pattern` 100, 101, 102, 100, 101, 102.
- **Stop, wrap, empty tag:**
  - `loop`=0, start=1022, len=3 → `rom_addr` runs 1022, 1023, 0, then `done`=1; further `step_en` leaves `pattern`=0.
  - len=0 → `done` 2 cycles after FETCH, with `pattern`=0.
- **Collisions and reset:** `up` and `dn` edges in the same cycle → no change and no fetch. An up edge coinciding with `step_en` in PLAY → FETCH, `pattern` unchanged. Reset mid-PLAY → all outputs return to their reset values asynchronously.
